// File: rtl/regfile_mp.sv
// regfile_mp: two-write-port register file with byte enables, optional zero register, bypass and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic [DATA_W-1:0]   rs1_data,
  output logic [DATA_W-1:0]   rs2_data,
  output logic                rs1_busy,
  output logic                rs2_busy,
  input  logic                wa_en,
  input  logic [ADDR_W-1:0]   wa_addr,
  input  logic [DATA_W-1:0]   wa_data,
  input  logic [DATA_W/8-1:0] wa_be,
  input  logic                wb_en,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic [DATA_W/8-1:0] wb_be,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                collision
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_next [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_whit;
  logic [DEPTH-1:0]  w_ihit;
  logic              r_collision;
  logic              w_wa_ok;
  logic              w_wb_ok;
  logic              w_is_ok;
  logic              w_rs1_ok;
  logic              w_rs2_ok;
  assign w_wa_ok  = wa_en && int'(wa_addr) < DEPTH && !(ZERO_REG != 0 && wa_addr == '0);
  assign w_wb_ok  = wb_en && int'(wb_addr) < DEPTH && !(ZERO_REG != 0 && wb_addr == '0);
  assign w_is_ok  = issue_en && int'(issue_addr) < DEPTH && !(ZERO_REG != 0 && issue_addr == '0);
  assign w_rs1_ok = int'(rs1_addr) < DEPTH && !(ZERO_REG != 0 && rs1_addr == '0);
  assign w_rs2_ok = int'(rs2_addr) < DEPTH && !(ZERO_REG != 0 && rs2_addr == '0);
  // Post-write value of every register (A bytes first, B overrides) plus per-register write/issue hits
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_next[k] = r_regs[k];
      for (int b = 0; b < NB; b++) begin
        if (w_wa_ok && int'(wa_addr) == k && wa_be[b]) w_next[k][8*b +: 8] = wa_data[8*b +: 8];
        if (w_wb_ok && int'(wb_addr) == k && wb_be[b]) w_next[k][8*b +: 8] = wb_data[8*b +: 8];
      end
      w_whit[k] = (w_wa_ok && int'(wa_addr) == k && |wa_be) || (w_wb_ok && int'(wb_addr) == k && |wb_be);
      w_ihit[k] = w_is_ok && int'(issue_addr) == k;
    end
  end
  // Asynchronous reads; bypass forwards merged data and lets a same-cycle write retire the busy flag
  always_comb begin
    rs1_data = !w_rs1_ok ? '0 : BYPASS != 0 ? w_next[rs1_addr] : r_regs[rs1_addr];
    rs2_data = !w_rs2_ok ? '0 : BYPASS != 0 ? w_next[rs2_addr] : r_regs[rs2_addr];
    rs1_busy = w_rs1_ok && r_busy[rs1_addr] && !(BYPASS != 0 && w_whit[rs1_addr] && !w_ihit[rs1_addr]);
    rs2_busy = w_rs2_ok && r_busy[rs2_addr] && !(BYPASS != 0 && w_whit[rs2_addr] && !w_ihit[rs2_addr]);
  end
  // Register, scoreboard and collision state; issue beats a same-cycle write on the busy bit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      r_busy      <= '0;
      r_collision <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= w_next[k];
      r_busy      <= w_ihit | (r_busy & ~w_whit);
      r_collision <= wa_en && wb_en && wa_addr == wb_addr && int'(wa_addr) < DEPTH;
    end
  end
  assign collision = r_collision;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for a bypassing 32-entry instance and a non-bypassing 24-entry instance
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, issue_addr;
  logic [31:0] wa_data, wb_data;
  logic [3:0]  wa_be, wb_be;
  logic        wa_en, wb_en, issue_en;
  logic [31:0] b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data;
  logic        b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy, b_coll, n_coll;
  logic [31:0] q[$];
  logic [31:0] e;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_mp u_byp (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
    .issue_en(issue_en), .issue_addr(issue_addr), .collision(b_coll)
  );

  regfile_mp #(.DEPTH(24), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(n_rs1_data), .rs2_data(n_rs2_data), .rs1_busy(n_rs1_busy), .rs2_busy(n_rs2_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_be(wa_be),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_be(wb_be),
    .issue_en(issue_en), .issue_addr(issue_addr), .collision(n_coll)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; issue_en = 0;
    wa_be = 0; wb_be = 0;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      q.push_back(32'h0);
      #1;
      e = q.pop_front();
      checks++;
      if (b_rs1_data !== e || b_rs2_data !== e || n_rs1_data !== e || n_rs2_data !== e) begin
        errors++;
        $display("FAIL reset_data addr %0d: got %h %h %h %h exp %h", a, b_rs1_data, b_rs2_data, n_rs1_data, n_rs2_data, e);
      end
      checks++;
      if ({b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy} !== 4'b0) begin
        errors++;
        $display("FAIL reset_busy addr %0d: got %b exp 0000", a, {b_rs1_busy, b_rs2_busy, n_rs1_busy, n_rs2_busy});
      end
    end
    checks++;
    if ({b_coll, n_coll} !== 2'b00) begin
      errors++;
      $display("FAIL reset_collision: got %b exp 00", {b_coll, n_coll});
    end
  endtask

  task automatic test_byte_write();
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; wa_be = 4'b1111;
    tick();
    wa_data = 32'h000000AA; wa_be = 4'b0001;
    q.push_back(32'hDEADBEAA);
    tick();
    idle();
    rs1_addr = 5;
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e || n_rs1_data !== e) begin
      errors++;
      $display("FAIL byte_write: got %h %h exp %h", b_rs1_data, n_rs1_data, e);
    end
  endtask

  task automatic test_collision();
    wa_en = 1; wa_addr = 7; wa_data = 32'h11111111; wa_be = 4'b1111;
    wb_en = 1; wb_addr = 7; wb_data = 32'h22222222; wb_be = 4'b0011;
    rs1_addr = 7;
    q.push_back(32'h11112222);
    q.push_back(32'h0);
    q.push_back(32'h11112222);
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e) begin
      errors++;
      $display("FAIL collision_bypass: got %h exp %h", b_rs1_data, e);
    end
    e = q.pop_front();
    checks++;
    if (n_rs1_data !== e) begin
      errors++;
      $display("FAIL collision_nobypass_pre: got %h exp %h", n_rs1_data, e);
    end
    tick();
    idle();
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e || n_rs1_data !== e) begin
      errors++;
      $display("FAIL collision_merge: got %h %h exp %h", b_rs1_data, n_rs1_data, e);
    end
    checks++;
    if ({b_coll, n_coll} !== 2'b11) begin
      errors++;
      $display("FAIL collision_flag: got %b exp 11", {b_coll, n_coll});
    end
    tick();
    checks++;
    if ({b_coll, n_coll} !== 2'b00) begin
      errors++;
      $display("FAIL collision_clear: got %b exp 00", {b_coll, n_coll});
    end
  endtask

  task automatic test_bypass();
    wa_en = 1; wa_addr = 3; wa_data = 32'h5A5A5A5A; wa_be = 4'b1111;
    rs2_addr = 3;
    q.push_back(32'h5A5A5A5A);
    q.push_back(32'h0);
    q.push_back(32'h5A5A5A5A);
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs2_data !== e) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h exp %h", b_rs2_data, e);
    end
    e = q.pop_front();
    checks++;
    if (n_rs2_data !== e) begin
      errors++;
      $display("FAIL nobypass_old: got %h exp %h", n_rs2_data, e);
    end
    tick();
    idle();
    #1;
    e = q.pop_front();
    checks++;
    if (n_rs2_data !== e || b_rs2_data !== e) begin
      errors++;
      $display("FAIL nobypass_new: got %h %h exp %h", n_rs2_data, b_rs2_data, e);
    end
  endtask

  task automatic test_scoreboard();
    issue_en = 1; issue_addr = 9;
    rs1_addr = 9;
    tick();
    issue_en = 0;
    q.push_back(32'h1);
    #1;
    e = q.pop_front();
    checks++;
    if ({31'b0, b_rs1_busy} !== e || {31'b0, n_rs1_busy} !== e) begin
      errors++;
      $display("FAIL busy_after_issue: got %b %b exp %0d", b_rs1_busy, n_rs1_busy, e);
    end
    wb_en = 1; wb_addr = 9; wb_data = 32'h99; wb_be = 4'b1111;
    #1;
    checks++;
    if ({b_rs1_busy, n_rs1_busy} !== 2'b01) begin
      errors++;
      $display("FAIL busy_write_same_cycle: got %b exp 01", {b_rs1_busy, n_rs1_busy});
    end
    tick();
    idle();
    #1;
    checks++;
    if ({b_rs1_busy, n_rs1_busy} !== 2'b00) begin
      errors++;
      $display("FAIL busy_cleared: got %b exp 00", {b_rs1_busy, n_rs1_busy});
    end
    issue_en = 1;
    tick();
    wa_en = 1; wa_addr = 9; wa_data = 32'h9; wa_be = 4'b1111;
    #1;
    checks++;
    if ({b_rs1_busy, n_rs1_busy} !== 2'b11) begin
      errors++;
      $display("FAIL busy_issue_and_write_comb: got %b exp 11", {b_rs1_busy, n_rs1_busy});
    end
    tick();
    idle();
    #1;
    checks++;
    if ({b_rs1_busy, n_rs1_busy} !== 2'b11) begin
      errors++;
      $display("FAIL busy_issue_wins: got %b exp 11", {b_rs1_busy, n_rs1_busy});
    end
    wa_en = 1; wa_be = 4'b1111;
    tick();
    idle();
    #1;
    checks++;
    if ({b_rs1_busy, n_rs1_busy} !== 2'b00) begin
      errors++;
      $display("FAIL busy_final_clear: got %b exp 00", {b_rs1_busy, n_rs1_busy});
    end
  endtask

  task automatic test_zero_reg();
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFFFFFF; wa_be = 4'b1111;
    issue_en = 1; issue_addr = 0;
    rs1_addr = 0;
    q.push_back(32'h0);
    q.push_back(32'h0);
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e) begin
      errors++;
      $display("FAIL zero_bypass: got %h exp %h", b_rs1_data, e);
    end
    tick();
    idle();
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e || n_rs1_data !== e || b_rs1_busy !== 1'b0 || n_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg: got %h %h busy %b%b exp %h busy 00", b_rs1_data, n_rs1_data, b_rs1_busy, n_rs1_busy, e);
    end
  endtask

  task automatic test_out_of_range();
    wa_en = 1; wa_addr = 30; wa_data = 32'h30303030; wa_be = 4'b1111;
    tick();
    idle();
    issue_en = 1; issue_addr = 30;
    tick();
    idle();
    rs1_addr = 30;
    q.push_back(32'h30303030);
    q.push_back(32'h0);
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e || b_rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL in_range_30: got %h busy %b exp %h busy 1", b_rs1_data, b_rs1_busy, e);
    end
    e = q.pop_front();
    checks++;
    if (n_rs1_data !== e || n_rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL out_of_range_30: got %h busy %b exp %h busy 0", n_rs1_data, n_rs1_busy, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      wa_en = 1; wa_addr = 5'(10 + i); wa_data = d; wa_be = 4'b1111;
      q.push_back(d);
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      rs2_addr = 5'(10 + i);
      #1;
      e = q.pop_front();
      checks++;
      if (b_rs2_data !== e || n_rs2_data !== e) begin
        errors++;
        $display("FAIL back_to_back addr %0d: got %h %h exp %h", 10 + i, b_rs2_data, n_rs2_data, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] addrs [6] = '{5'd3, 5'd5, 5'd7, 5'd9, 5'd12, 5'd30};
    reset = 1;
    wa_en = 1; wa_addr = 12; wa_data = 32'hCAFEF00D; wa_be = 4'b1111;
    issue_en = 1; issue_addr = 12;
    wb_en = 1; wb_addr = 12; wb_data = 32'h1; wb_be = 4'b0001;
    rs1_addr = 5;
    q.push_back(32'hDEADBEAA);
    #1;
    e = q.pop_front();
    checks++;
    if (b_rs1_data !== e) begin
      errors++;
      $display("FAIL reset_old_read: got %h exp %h", b_rs1_data, e);
    end
    tick();
    reset = 0;
    idle();
    for (int i = 0; i < 6; i++) begin
      rs1_addr = addrs[i];
      q.push_back(32'h0);
      #1;
      e = q.pop_front();
      checks++;
      if (b_rs1_data !== e || n_rs1_data !== e || b_rs1_busy !== 1'b0 || n_rs1_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid addr %0d: got %h %h busy %b%b exp %h busy 00", addrs[i], b_rs1_data, n_rs1_data, b_rs1_busy, n_rs1_busy, e);
      end
    end
    checks++;
    if ({b_coll, n_coll} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_collision: got %b exp 00", {b_coll, n_coll});
    end
  endtask

  initial begin
    reset = 1;
    rs1_addr = 0; rs2_addr = 0; wa_addr = 0; wb_addr = 0; issue_addr = 0;
    wa_data = 0; wb_data = 0;
    idle();
    tick();
    tick();
    reset = 0;
    test_reset();
    test_byte_write();
    test_collision();
    test_bypass();
    test_scoreboard();
    test_zero_reg();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised two-write-port register file with per-register busy scoreboard. Successor to the single-write-port register file of the single-cycle core, sized for the pipelined core.
- Port A: ALU write-back. Port B: load/late write-back. Both have byte enables.
- Optional hardwired-zero register and optional same-cycle write-to-read bypass.
- Busy scoreboard lets decode stall on operands whose producer is still in flight.

Parameters:
DATA_W, 32, register width in bits (multiple of 8)
ADDR_W, 5, register address width
DEPTH, 32, number of registers (2 <= DEPTH <= 2**ADDR_W)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy
BYPASS, 1, 1 = same-cycle writes forwarded to read ports and clear busy flags combinationally

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all registers, busy bits and collision
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  DATA_W  read port 1 data (combinational)
rs2_data  out  DATA_W  read port 2 data (combinational)
rs1_busy  out  1  scoreboard busy for rs1_addr (combinational)
rs2_busy  out  1  scoreboard busy for rs2_addr (combinational)
wa_en  in  1  write port A enable
wa_addr  in  ADDR_W  write port A address
wa_data  in  DATA_W  write port A data
wa_be  in  DATA_W/8  write port A byte enables
wb_en  in  1  write port B enable
wb_addr  in  ADDR_W  write port B address
wb_data  in  DATA_W  write port B data
wb_be  in  DATA_W/8  write port B byte enables
issue_en  in  1  mark issue_addr busy (producer issued)
issue_addr  in  ADDR_W  destination of issued instruction
collision  out  1  registered; 1 for the cycle after A and B wrote the same address

Behaviour:
- Reset (rising edge with reset=1):
  - All DEPTH registers <= 0; all busy bits <= 0; collision <= 0.
  - Writes and issue in that cycle are ignored.
  - Reads before the edge return the old contents.
- Write: at the rising edge, for each enabled port, each byte i with be[i]=1 is updated from that port's data. Bytes with be[i]=0 keep their value. An all-zero be is a no-op.
- Same-address A/B write: port B wins for every byte it enables. Port A still writes the bytes only it enables. collision <= 1 for the next cycle, otherwise collision <= 0.
- Out-of-range handling:
  - Address >= DEPTH on a write port or issue: ignored.
  - Address >= DEPTH on a read port: data 0, busy 0.
- ZERO_REG=1:
  - Writes and issue to address 0 are ignored; rs*_data for address 0 = 0; rs*_busy for address 0 = 0.
  - collision is still flagged for address 0.
- Reads: asynchronous, rsX_data = register[rsX_addr].
- BYPASS=1:
  - The read value is the merged post-write value for the current cycle: stored data with enabled A bytes replaced, then enabled B bytes replaced.
  - Reads therefore see writes with zero latency.
- BYPASS=0: writes become visible the cycle after the edge.
- Scoreboard:
  - issue_en sets busy[issue_addr] at the edge.
  - Any write (either port, any nonzero be) clears busy[addr] at the edge.
  - Issue and write to the same address in the same cycle: issue wins, busy stays 1.
- rsX_busy:
  - Base value is busy[rsX_addr].
  - With BYPASS=1, it is forced to 0 when a same-cycle write targets rsX_addr and there is no same-cycle issue to that address.
  - Same-cycle issue never sets rsX_busy combinationally.
- Both read ports are independent and may share an address.

Test Plan:
- Reset, then read all addresses -> every rs*_data = 0, every rs*_busy = 0, collision = 0.
- Write A: addr 5, data 0xDEADBEEF, be 4'b1111; next cycle write A: addr 5, data 0x000000AA, be 4'b0001 -> rs1 at 5 reads 0xDEADBEAA.
- A and B same cycle: both addr 7, A data 0x11111111 be 1111, B data 0x22222222 be 0011 -> reg7 = 0x11112222, collision = 1 for exactly one cycle.
- BYPASS=1: wa addr 3 data 0x5A5A5A5A and rs2_addr=3 in the same cycle -> rs2_data = 0x5A5A5A5A before the edge.
- BYPASS=0 variant: same stimulus -> rs2_data = old value before the edge, new value after.
- Scoreboard:
  - issue addr 9 -> rs1_busy = 1 next cycle.
  - wb write addr 9 -> rs1_busy = 0 in that cycle with BYPASS=1, and at the next edge in all cases.
  - issue + write to 9 in the same cycle -> stays busy.
- ZERO_REG=1: write 0xFFFFFFFF to addr 0, issue addr 0 -> rs1_data = 0, rs1_busy = 0.
- Reset asserted mid-stream with wa_en and issue_en active -> all registers 0, busy 0 after the edge.
